// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the tamagotchi needs engine: mood encodings,
// the mood width and a small sizing helper.
package tamagotchi_pkg;

    localparam int MOOD_W = 2;

    typedef enum logic [MOOD_W-1:0] {
        MOOD_OK   = 2'b00,
        MOOD_WARN = 2'b01,
        MOOD_CRIT = 2'b10,
        MOOD_DEAD = 2'b11
    } mood_e;

    // Counter width for a value range, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/tamagotchi_tick_gen.sv
// Decay-tick prescaler for the needs engine. Counts 0..T-1 and raises o_tick
// during the last count. With TAMA_TEST_MODE_EN defined, a rising edge on
// i_btn_test toggles a test mode that shortens T by TEST_DIV and restarts the
// count. Without the macro the test button is ignored.
module tamagotchi_tick_gen
    import tamagotchi_pkg::*;
#(
    parameter int DECAY_TICKS = 50_000_000,
    parameter int TEST_DIV    = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_test,
    output logic o_tick,
    output logic o_test_mode
);

    localparam int T_NORM = (DECAY_TICKS < 1) ? 1 : DECAY_TICKS;
    localparam int CNT_W  = clog2_min1(T_NORM);
    localparam logic [CNT_W-1:0] LAST_NORM = CNT_W'(T_NORM - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    logic             w_clear;

`ifdef TAMA_TEST_MODE_EN
    localparam int DIV_SAFE   = (TEST_DIV < 1) ? 1 : TEST_DIV;
    localparam int T_TEST_RAW = T_NORM / DIV_SAFE;
    localparam int T_TEST     = (T_TEST_RAW < 1) ? 1 : T_TEST_RAW;
    localparam logic [CNT_W-1:0] LAST_TEST = CNT_W'(T_TEST - 1);

    logic r_test_cur;
    logic r_test_prev;
    logic r_test_mode;
    logic w_test_rise;

    assign w_test_rise = r_test_cur & ~r_test_prev;

    // Register the test button twice for edge detection; toggle mode on a rise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_test_cur  <= 1'b0;
            r_test_prev <= 1'b0;
            r_test_mode <= 1'b0;
        end else begin
            r_test_cur  <= i_btn_test;
            r_test_prev <= r_test_cur;
            if (w_test_rise) begin
                r_test_mode <= ~r_test_mode;
            end
        end
    end

    assign w_last      = (r_cnt == (r_test_mode ? LAST_TEST : LAST_NORM));
    assign w_clear     = w_test_rise;
    assign o_test_mode = r_test_mode;
`else
    logic w_unused_btn_test;
    assign w_unused_btn_test = i_btn_test;

    assign w_last      = (r_cnt == LAST_NORM);
    assign w_clear     = 1'b0;
    assign o_test_mode = 1'b0;
`endif

    // Prescaler: wrap on the last count, restart whenever the mode toggles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_clear || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Tick is decoded straight from the counter register.
    assign o_tick = w_last;

endmodule

// File: rtl/tamagotchi_needs_core.sv
// Needs engine: NUM_NEEDS levels decayed round-robin on the prescaled tick,
// replenished by button rising edges, with a registered mood FSM
// (OK/WARN/CRITICAL/DEAD) and per-need alert flags. The optional test mode
// (faster ticks toggled by i_btn_test) is built only when TAMA_TEST_MODE_EN
// is defined; see tamagotchi_tick_gen.
module tamagotchi_needs_core
    import tamagotchi_pkg::*;
#(
    parameter int NUM_NEEDS   = 4,
    parameter int LEVEL_W     = 3,
    parameter int MAX_LEVEL   = 5,
    parameter int WARN_LEVEL  = 2,
    parameter int FEED_STEP   = 2,
    parameter int DECAY_TICKS = 50_000_000,
    parameter int TEST_DIV    = 10,
    parameter int DEAD_TICKS  = 3
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_NEEDS-1:0]         i_btn_need,
    input  logic                         i_btn_test,
    output logic [NUM_NEEDS*LEVEL_W-1:0] o_level,
    output logic [NUM_NEEDS-1:0]         o_alert,
    output logic [MOOD_W-1:0]            o_mood,
    output logic                         o_test_mode,
    output logic                         o_tick_out
);

    localparam int PTR_W  = clog2_min1(NUM_NEEDS);
    localparam int SUM_W  = LEVEL_W + clog2_min1(FEED_STEP + 1) + 1;
    localparam int DCNT_W = clog2_min1(DEAD_TICKS + 1);

    localparam logic [LEVEL_W-1:0] MAX_L    = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] WARN_L   = LEVEL_W'(WARN_LEVEL);
    localparam logic [SUM_W-1:0]   MAX_S    = SUM_W'(MAX_LEVEL);
    localparam logic [SUM_W-1:0]   STEP_S   = SUM_W'(FEED_STEP);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(NUM_NEEDS - 1);
    localparam logic [DCNT_W-1:0]  DEAD_LIM = DCNT_W'(DEAD_TICKS);

    logic                              w_tick;
    logic                              w_test_mode;
    logic [NUM_NEEDS-1:0]              r_btn_cur;
    logic [NUM_NEEDS-1:0]              r_btn_prev;
    logic [NUM_NEEDS-1:0]              w_rise;
    logic [NUM_NEEDS-1:0][LEVEL_W-1:0] r_level;
    logic [NUM_NEEDS-1:0][LEVEL_W-1:0] w_level_next;
    logic [NUM_NEEDS-1:0]              w_low;
    logic [NUM_NEEDS-1:0]              w_zero;
    logic [PTR_W-1:0]                  r_ptr;
    logic [DCNT_W-1:0]                 r_dead_cnt;
    logic [NUM_NEEDS-1:0]              r_alert;
    mood_e                             r_mood;
    mood_e                             w_target;
    logic                              w_dead;

    tamagotchi_tick_gen #(
        .DECAY_TICKS (DECAY_TICKS),
        .TEST_DIV    (TEST_DIV)
    ) u_tick_gen (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_btn_test  (i_btn_test),
        .o_tick      (w_tick),
        .o_test_mode (w_test_mode)
    );

    // Two-stage register on the buttons so a held button yields one event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btn_cur  <= '0;
            r_btn_prev <= '0;
        end else begin
            r_btn_cur  <= i_btn_need;
            r_btn_prev <= r_btn_cur;
        end
    end

    assign w_rise = r_btn_cur & ~r_btn_prev;
    assign w_dead = (r_mood == MOOD_DEAD);

    // Per-channel next level: decay first (saturating at 0), then feed with
    // saturation at MAX_LEVEL, so a same-cycle decay and feed combine.
    for (genvar gi = 0; gi < NUM_NEEDS; gi++) begin : g_need
        logic               w_hit;
        logic [LEVEL_W-1:0] w_dec;
        logic [SUM_W-1:0]   w_sum;

        assign w_hit = w_tick && (r_ptr == PTR_W'(gi));
        assign w_dec = (w_hit && (r_level[gi] != '0)) ? r_level[gi] - LEVEL_W'(1)
                                                       : r_level[gi];
        assign w_sum = SUM_W'(w_dec) + STEP_S;
        assign w_level_next[gi] = !w_rise[gi]   ? w_dec :
                                  (w_sum > MAX_S) ? MAX_L : w_sum[LEVEL_W-1:0];
        assign w_low[gi]  = (r_level[gi] <= WARN_L);
        assign w_zero[gi] = (r_level[gi] == '0);
    end

    // Level registers; frozen once the pet is dead.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= {NUM_NEEDS{MAX_L}};
        end else if (!w_dead) begin
            r_level <= w_level_next;
        end
    end

    // Round-robin decay pointer advances on every tick while alive.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_tick && !w_dead) begin
            r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
        end
    end

    assign w_target = (|w_zero) ? MOOD_CRIT :
                      (|w_low)  ? MOOD_WARN : MOOD_OK;

    // Mood FSM and alerts, both registered from the current level registers.
    // The dead counter counts ticks spent in CRITICAL and clears on exit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mood     <= MOOD_OK;
            r_dead_cnt <= '0;
            r_alert    <= '0;
        end else begin
            r_alert <= w_low;
            case (r_mood)
                MOOD_DEAD: begin
                    r_mood <= MOOD_DEAD;
                end
                MOOD_CRIT: begin
                    if (r_dead_cnt >= DEAD_LIM) begin
                        r_mood <= MOOD_DEAD;
                    end else if (w_target != MOOD_CRIT) begin
                        r_mood     <= w_target;
                        r_dead_cnt <= '0;
                    end else if (w_tick) begin
                        r_dead_cnt <= r_dead_cnt + DCNT_W'(1);
                    end
                end
                default: begin
                    r_mood     <= w_target;
                    r_dead_cnt <= '0;
                end
            endcase
        end
    end

    assign o_level     = r_level;
    assign o_alert     = r_alert;
    assign o_mood      = r_mood;
    assign o_test_mode = w_test_mode;
    assign o_tick_out  = w_tick;

endmodule

// File: tb/tb_tamagotchi_needs_core.sv
// Directed bench for tamagotchi_needs_core with DECAY_TICKS=8, TEST_DIV=4.
// Inputs change 1 time unit after a rising edge; checks happen at that point.
// Edge numbers in comments count rising edges since reset release.
module tb_tamagotchi_needs_core;
    import tamagotchi_pkg::*;

`ifdef TAMA_TEST_MODE_EN
    localparam bit TM_EN = 1'b1;
`else
    localparam bit TM_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  btn_need;
    logic        btn_test;
    logic [11:0] level;
    logic [3:0]  alert;
    logic [1:0]  mood;
    logic        test_mode;
    logic        tick_out;

    int checks;
    int failures;

    tamagotchi_needs_core #(
        .NUM_NEEDS   (4),
        .LEVEL_W     (3),
        .MAX_LEVEL   (5),
        .WARN_LEVEL  (2),
        .FEED_STEP   (2),
        .DECAY_TICKS (8),
        .TEST_DIV    (4),
        .DEAD_TICKS  (3)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_btn_need  (btn_need),
        .i_btn_test  (btn_test),
        .o_level     (level),
        .o_alert     (alert),
        .o_mood      (mood),
        .o_test_mode (test_mode),
        .o_tick_out  (tick_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pk(input logic [2:0] l3, input logic [2:0] l2,
                                       input logic [2:0] l1, input logic [2:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        if (obs === exp) $display("ok   %-16s value=0x%0h", tag, obs);
    endtask

    logic [11:0] exp_decay [3];

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        btn_need = 4'b0000;
        btn_test = 1'b0;
        exp_decay[0] = pk(3'd5, 3'd5, 3'd4, 3'd4);
        exp_decay[1] = pk(3'd5, 3'd4, 3'd4, 3'd4);
        exp_decay[2] = pk(3'd4, 3'd4, 3'd4, 3'd4);

        // Reset state
        step(2);
        chk("rst_level", 32'(level), 32'(pk(3'd5, 3'd5, 3'd5, 3'd5)));
        chk("rst_mood",  32'(mood), 32'(MOOD_OK));
        chk("rst_alert", 32'(alert), 32'h0);
        chk("rst_tm",    32'(test_mode), 32'h0);
        chk("rst_tick",  32'(tick_out), 32'h0);
        rst_n = 1'b1;

        // First tick after 8 cycles, decaying need 0, then needs 1..3
        step(7);                                                 // edge 7
        chk("tick1_pulse", 32'(tick_out), 32'h1);
        chk("tick1_hold",  32'(level), 32'(pk(3'd5, 3'd5, 3'd5, 3'd5)));
        step(1);                                                 // edge 8
        chk("decay_n0", 32'(level), 32'(pk(3'd5, 3'd5, 3'd5, 3'd4)));
        chk("tick1_end", 32'(tick_out), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(7);
            chk("tick_spacing", 32'(tick_out), 32'h1);
            step(1);                                             // edges 16,24,32
            chk("decay_rr", 32'(level), 32'(exp_decay[k]));
        end
        chk("mood_ok", 32'(mood), 32'(MOOD_OK));

        // Hold btn_need[1] for 20 cycles: one feed only
        btn_need = 4'b0010;
        step(2);                                                 // edge 34
        chk("feed_sat", 32'(level), 32'(pk(3'd4, 3'd4, 3'd5, 3'd4)));
        step(18);                                                // edge 52
        chk("hold_once", 32'(level), 32'(pk(3'd4, 3'd4, 3'd4, 3'd3)));
        btn_need = 4'b0000;

        // Let need 1 decay to 2, then a single press
        step(60);                                                // edge 112
        chk("pre_feed", 32'(level), 32'(pk(3'd2, 3'd2, 3'd2, 3'd1)));
        btn_need = 4'b0010;
        step(1);                                                 // edge 113
        chk("mood_warn", 32'(mood), 32'(MOOD_WARN));
        btn_need = 4'b0000;
        step(1);                                                 // edge 114
        chk("feed_2to4", 32'(level), 32'(pk(3'd2, 3'd2, 3'd4, 3'd1)));
        step(1);                                                 // edge 115
        chk("alert_mix", 32'(alert), 32'hD);

        // Two buttons rising together
        step(5);                                                 // edge 120
        btn_need = 4'b1001;
        step(1);
        btn_need = 4'b0000;
        step(1);                                                 // edge 122
        chk("multi_feed", 32'(level), 32'(pk(3'd4, 3'd1, 3'd4, 3'd3)));

        // Tick on need 2 and its button rise in the same cycle
        step(28);                                                // edge 150
        btn_need = 4'b0100;
        step(1);                                                 // edge 151
        chk("same_tick", 32'(tick_out), 32'h1);
        btn_need = 4'b0000;
        step(1);                                                 // edge 152
        chk("decay_feed", 32'(level), 32'(pk(3'd3, 3'd2, 3'd3, 3'd2)));
        step(1);                                                 // edge 153
        chk("alert_df", 32'(alert), 32'h5);
        chk("mood_df",  32'(mood), 32'(MOOD_WARN));

        // Need 0 reaches zero, CRITICAL, then recover with counter at 2
        step(47);                                                // edge 200
        chk("zero_n0", 32'(level), 32'(pk(3'd1, 3'd1, 3'd2, 3'd0)));
        step(1);                                                 // edge 201
        chk("mood_crit", 32'(mood), 32'(MOOD_CRIT));
        step(15);                                                // edge 216
        chk("crit_cnt2", 32'(mood), 32'(MOOD_CRIT));
        btn_need = 4'b0101;
        step(1);
        btn_need = 4'b0000;
        step(1);                                                 // edge 218
        chk("rescue_lvl", 32'(level), 32'(pk(3'd1, 3'd2, 3'd1, 3'd2)));
        step(1);                                                 // edge 219
        chk("rescue_mood", 32'(mood), 32'(MOOD_WARN));

        // Fresh CRITICAL needs three new ticks
        step(6);                                                 // edge 225
        chk("crit_again", 32'(mood), 32'(MOOD_CRIT));
        step(8);                                                 // edge 233
        chk("cnt_cleared", 32'(mood), 32'(MOOD_CRIT));
        step(15);                                                // edge 248
        chk("crit_3rd_tick", 32'(mood), 32'(MOOD_CRIT));
        step(1);                                                 // edge 249
        chk("mood_dead", 32'(mood), 32'(MOOD_DEAD));
        chk("dead_level", 32'(level), 32'(pk(3'd0, 3'd1, 3'd0, 3'd1)));

        // DEAD: buttons ignored, levels frozen, ticks keep coming
        btn_need = 4'b1111;
        step(1);
        btn_need = 4'b0000;
        step(3);                                                 // edge 253
        chk("dead_nofeed", 32'(level), 32'(pk(3'd0, 3'd1, 3'd0, 3'd1)));
        step(2);                                                 // edge 255
        chk("dead_tick", 32'(tick_out), 32'h1);
        step(2);                                                 // edge 257
        chk("dead_frozen", 32'(level), 32'(pk(3'd0, 3'd1, 3'd0, 3'd1)));
        chk("dead_stays", 32'(mood), 32'(MOOD_DEAD));

        // Asynchronous reset takes effect without a clock edge
        rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 32'(pk(3'd5, 3'd5, 3'd5, 3'd5)));
        chk("arst_mood",  32'(mood), 32'(MOOD_OK));
        chk("arst_alert", 32'(alert), 32'h0);
        step(1);
        rst_n = 1'b1;                                            // edge 0

        // Test-mode toggle (no effect when the feature is not built)
        btn_test = 1'b1;
        step(1);                                                 // edge 1
        btn_test = 1'b0;
        step(1);                                                 // edge 2
        chk("tm_on", 32'(test_mode), 32'(TM_EN));
        step(1);                                                 // edge 3
        chk("tm_tick_a", 32'(tick_out), 32'(TM_EN));
        step(2);                                                 // edge 5
        chk("tm_tick_b", 32'(tick_out), 32'(TM_EN));
        btn_test = 1'b1;
        step(1);                                                 // edge 6
        btn_test = 1'b0;
        step(1);                                                 // edge 7
        chk("tm_off", 32'(test_mode), 32'h0);
        chk("tm_off_tick", 32'(tick_out), 32'(!TM_EN));
        step(7);                                                 // edge 14
        chk("norm_tick_a", 32'(tick_out), 32'(TM_EN));
        step(1);                                                 // edge 15
        chk("norm_tick_b", 32'(tick_out), 32'(!TM_EN));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
